// File: rtl/qosc_monitor.sv
// rtl/qosc_monitor.sv - receive-side checker for the quadrature oscillator sample stream
// Optional feature macro: QOSC_MON_POWER_ERR_EN (builds the power - target_power subtractor)
// Accepts one (re, im) sample per handshake, squares both parts bit-serially into
// power = re^2 + im^2, tracks the phasor quadrant and measures samples per revolution.
module qosc_monitor #(
  parameter int W      = 8,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_re,
  input  logic [W-1:0]      s_im,
  input  logic [2*W-1:0]    target_power,
  output logic [2*W-1:0]    power,
  output logic              power_valid,
  output logic [1:0]        quadrant,
  output logic [PCNT_W-1:0] period,
  output logic              period_valid,
  output logic              dir,
  output logic              err_skip,
  output logic              err_ovf,
  output logic [2*W:0]      power_err
);

  localparam int BC_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(W - 1);
  localparam logic [PCNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SQ_RE = 2'd1,
    S_SQ_IM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // squarer datapath
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_im_abs;
  logic [BC_W-1:0] r_bitcnt;
  logic [2*W-1:0] r_power;

  // quadrant / revolution tracking
  logic [1:0]        r_quadrant;
  logic [PCNT_W-1:0] r_count;
  logic              r_armed;
  logic [PCNT_W-1:0] r_period;
  logic              r_period_valid;
  logic              r_dir;
  logic              r_err_skip;
  logic              r_err_ovf;

  logic              w_transfer;
  logic              w_bit_last;
  logic [W-1:0]      w_re_abs;
  logic [W-1:0]      w_im_abs;
  logic [2*W-1:0]    w_acc_next;
  logic [1:0]        w_quad;
  logic              w_bnd_ccw;
  logic              w_bnd_cw;
  logic              w_skip;
  logic [PCNT_W-1:0] w_count_inc;
  logic              w_count_sat;

  // magnitude of a signed sample; the most negative value maps onto 2^(W-1) unsigned
  assign w_re_abs = s_re[W-1] ? (~s_re + 1'b1) : s_re;
  assign w_im_abs = s_im[W-1] ? (~s_im + 1'b1) : s_im;

  assign w_transfer = s_valid && s_ready;
  assign w_bit_last = (r_bitcnt == BIT_LAST);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // quadrant code: {im negative, re and im signs differ}
  assign w_quad      = {s_im[W-1], s_im[W-1] ^ s_re[W-1]};
  assign w_bnd_ccw   = (r_quadrant == 2'd3) && (w_quad == 2'd0);
  assign w_bnd_cw    = (r_quadrant == 2'd0) && (w_quad == 2'd3);
  assign w_skip      = ((r_quadrant ^ w_quad) == 2'b10);
  assign w_count_inc = r_count + PCNT_W'(1);
  assign w_count_sat = (r_count == CNT_MAX);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next state and handshake/strobe outputs; DONE also accepts the next sample
  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    power_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_state_next = S_SQ_RE;
        end
      end
      S_SQ_RE: begin
        if (w_bit_last) begin
          w_state_next = S_SQ_IM;
        end
      end
      S_SQ_IM: begin
        if (w_bit_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        s_ready     = 1'b1;
        power_valid = 1'b1;
        w_state_next = s_valid ? S_SQ_RE : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // shift-add squarer: one multiplier bit per cycle, LSB first, re^2 then im^2 into one accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_im_abs <= '0;
      r_bitcnt <= '0;
      r_power  <= '0;
    end else if (w_transfer) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, w_re_abs};
      r_mplier <= w_re_abs;
      r_im_abs <= w_im_abs;
      r_bitcnt <= '0;
    end else if (r_state == S_SQ_RE || r_state == S_SQ_IM) begin
      r_acc <= w_acc_next;
      if (w_bit_last) begin
        r_bitcnt <= '0;
        r_mcand  <= {{W{1'b0}}, r_im_abs};
        r_mplier <= r_im_abs;
        if (r_state == S_SQ_IM) begin
          r_power <= w_acc_next;
        end
      end else begin
        r_bitcnt <= r_bitcnt + BC_W'(1);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

  // quadrant, skip detection and revolution period measurement at each transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quadrant     <= 2'd0;
      r_count        <= '0;
      r_armed        <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_dir          <= 1'b0;
      r_err_skip     <= 1'b0;
      r_err_ovf      <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (w_transfer) begin
        r_quadrant <= w_quad;
        if (w_skip) begin
          r_err_skip <= 1'b1;
        end
        if (w_bnd_ccw || w_bnd_cw) begin
          r_count <= '0;
          r_armed <= 1'b1;
          if (r_armed) begin
            // the boundary sample itself belongs to the revolution it closes
            r_period       <= w_count_sat ? CNT_MAX : w_count_inc;
            r_period_valid <= 1'b1;
            r_dir          <= w_bnd_cw;
          end
        end else if (!w_count_sat) begin
          r_count <= w_count_inc;
          if (w_count_inc == CNT_MAX) begin
            r_err_ovf <= 1'b1;
          end
        end
      end
    end
  end

`ifdef QOSC_MON_POWER_ERR_EN
  logic [2*W:0] r_power_err;

  // signed deviation from the expected power, loaded alongside power
  always_ff @(posedge clk) begin
    if (rst) begin
      r_power_err <= '0;
    end else if (r_state == S_SQ_IM && w_bit_last) begin
      r_power_err <= {1'b0, w_acc_next} - {1'b0, target_power};
    end
  end

  assign power_err = r_power_err;
`else
  logic w_unused_target;

  assign w_unused_target = ^target_power;
  assign power_err       = '0;
`endif

  assign power        = r_power;
  assign quadrant     = r_quadrant;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign dir          = r_dir;
  assign err_skip     = r_err_skip;
  assign err_ovf      = r_err_ovf;

endmodule
